stierlitz_bus_target: RTL and testbench

//  Parametrised sector-bus target for the Stierlitz USB mass-storage bridge; replaces the fixed

---
 rtl/stierlitz_bus_target_if.sv | 29 ++
 rtl/stierlitz_bus_target.sv | 142 ++++++++++++++
 tb/tb_stierlitz_bus_target.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stierlitz_bus_target_if.sv
// Sector-bus handshake bundle between the stierlitz bridge (master) and a
// bus target (slave). The 8-bit data lane is bidirectional and is carried
// as a separate inout port on the target, so it is not part of this bundle.
//   bus_address  : byte address, sampled by the target at start
//   bus_rw       : 1 = read (target drives data), 0 = write
//   bus_start_op : single-cycle start strobe
//   bus_ready    : 1 = target idle / previous op complete
interface stierlitz_bus_target_if #(
    parameter int ADDR_WIDTH = 41
);
    logic [ADDR_WIDTH-1:0] bus_address;
    logic                  bus_rw;
    logic                  bus_start_op;
    logic                  bus_ready;

    modport master (
        output bus_address,
        output bus_rw,
        output bus_start_op,
        input  bus_ready
    );

    modport slave (
        input  bus_address,
        input  bus_rw,
        input  bus_start_op,
        output bus_ready
    );
endinterface

// File: rtl/stierlitz_bus_target.sv
// Parametrised sector-bus target for the Stierlitz USB mass-storage bridge.
// Answers bus_start_op after WAIT_STATES extra cycles, serving constant,
// address-derived or small-RAM data, and exports LED/activity/error status.
// Ports:
//   clk, reset    : single clock, synchronous active-high reset
//   enable        : 1 = accept new ops
//   mode          : 0 const, 1 addr pattern, 2 RAM r/w, 3 RAM write-protected
//   clear_status  : clears op_count, wp_err, overrun (priority over updates)
//   bus           : handshake bundle (address, rw, start, ready)
//   bus_data      : bidirectional data, driven only while bus.bus_rw = 1
//   led_byte      : address slice latched at accept
//   activity      : stretched op indicator
//   op_count      : completed ops, wrapping
//   wp_err        : sticky, write attempted in mode 3
//   overrun       : sticky, start seen while busy
module stierlitz_bus_target #(
    parameter int          ADDR_WIDTH   = 41,
    parameter int          DEPTH        = 512,
    parameter int          WAIT_STATES  = 0,
    parameter logic [7:0]  PATTERN      = 8'hAA,
    parameter int          LED_LSB      = 9,
    parameter int          STRETCH_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic                   clear_status,
    stierlitz_bus_target_if.slave  bus,
    inout  wire  [7:0]             bus_data,
    output logic [7:0]             led_byte,
    output logic                   activity,
    output logic [15:0]            op_count,
    output logic                   wp_err,
    output logic                   overrun
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]              state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rw_q;
    logic [1:0]              mode_q;
    logic [7:0]              wbyte_q;
    logic [7:0]              rd_data;
    logic [7:0]              cnt;
    logic [STRETCH_BITS-1:0] act_cnt;
    logic [7:0]              ram [DEPTH];

    logic                    accept;
    logic                    finish;
    logic [IDX_W-1:0]        idx;
    logic                    addr_unused_bits;

    assign accept = (state == ST_IDLE) && bus.bus_start_op && enable;
    assign finish = (state == ST_BUSY) && (cnt == 8'd0);
    assign idx    = addr_q[IDX_W-1:0];

    // Upper address bits only matter to the host; fold them so they are consumed.
    assign addr_unused_bits = ^addr_q;

    // Ready is low for the whole BUSY stay; while idle it tracks enable.
    assign bus.bus_ready = (state == ST_IDLE) && enable;

    // Direction follows the live rw pin, not the latched one.
    assign bus_data = bus.bus_rw ? rd_data : 8'bz;

    assign activity = (act_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            mode_q   <= 2'd0;
            wbyte_q  <= '0;
            rd_data  <= 8'h00;
            cnt      <= '0;
            led_byte <= '0;
            act_cnt  <= '0;
            op_count <= '0;
            wp_err   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= bus.bus_address;
                rw_q     <= bus.bus_rw;
                mode_q   <= mode;
                wbyte_q  <= bus_data;
                cnt      <= 8'(WAIT_STATES);
                led_byte <= bus.bus_address[LED_LSB +: 8];
                state    <= ST_BUSY;
            end else if (state == ST_BUSY) begin
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    state <= ST_IDLE;
                    if (rw_q) begin
                        case (mode_q)
                            2'd0:    rd_data <= PATTERN;
                            2'd1:    rd_data <= addr_q[7:0] ^ addr_q[15:8];
                            default: rd_data <= ram[idx];
                        endcase
                    end
                end
            end

            if (accept) begin
                act_cnt <= '1;
            end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 1'b1;
            end

            // Clear wins over any same-cycle increment or sticky set.
            if (clear_status) begin
                op_count <= '0;
                wp_err   <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (finish) begin
                    op_count <= op_count + 16'd1;
                end
                if (finish && !rw_q && (mode_q == 2'd3)) begin
                    wp_err <= 1'b1;
                end
                // Completion edge still counts as busy, so a start here is an overrun.
                if ((state == ST_BUSY) && bus.bus_start_op) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // RAM is never cleared; a reset on the completion edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && finish && !rw_q && (mode_q == 2'd2)) begin
            ram[idx] <= wbyte_q;
        end
    end
endmodule

// File: tb/tb_stierlitz_bus_target.sv
module tb_stierlitz_bus_target;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        clear_status = 1'b0;
    logic [40:0] addr = '0;
    logic        rw = 1'b1;
    logic        start = 1'b0;
    logic        tb_drive = 1'b0;
    logic [7:0]  tb_wdata = 8'h00;

    wire  [7:0]  bus_data0;
    wire  [7:0]  bus_data3;
    logic [7:0]  led0, led3;
    logic        act0, act3;
    logic [15:0] cnt0, cnt3;
    logic        wp0, wp3, ovr0, ovr3;
    logic        ready0, ready3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stierlitz_bus_target_if #(.ADDR_WIDTH(41)) bif0 ();
    stierlitz_bus_target_if #(.ADDR_WIDTH(41)) bif3 ();

    assign bif0.bus_address  = addr;
    assign bif0.bus_rw       = rw;
    assign bif0.bus_start_op = start;
    assign bif3.bus_address  = addr;
    assign bif3.bus_rw       = rw;
    assign bif3.bus_start_op = start;
    assign ready0 = bif0.bus_ready;
    assign ready3 = bif3.bus_ready;

    assign bus_data0 = tb_drive ? tb_wdata : 8'bz;
    assign bus_data3 = tb_drive ? tb_wdata : 8'bz;

    stierlitz_bus_target #(
        .ADDR_WIDTH(41), .DEPTH(512), .WAIT_STATES(0), .PATTERN(8'hAA),
        .LED_LSB(9), .STRETCH_BITS(20)
    ) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .clear_status(clear_status), .bus(bif0.slave), .bus_data(bus_data0),
        .led_byte(led0), .activity(act0), .op_count(cnt0),
        .wp_err(wp0), .overrun(ovr0)
    );

    stierlitz_bus_target #(
        .ADDR_WIDTH(41), .DEPTH(512), .WAIT_STATES(3), .PATTERN(8'hAA),
        .LED_LSB(9), .STRETCH_BITS(4)
    ) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .clear_status(clear_status), .bus(bif3.slave), .bus_data(bus_data3),
        .led_byte(led3), .activity(act3), .op_count(cnt3),
        .wp_err(wp3), .overrun(ovr3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ready0 && ready3) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!(ready0 && ready3)) begin
            errors++;
            $display("FAIL wait_idle_timeout: ready0=%b ready3=%b required both 1", ready0, ready3);
        end
    endtask

    task automatic do_op(input logic [40:0] a, input logic r, input logic [7:0] wd);
        addr = a;
        rw = r;
        tb_wdata = wd;
        tb_drive = !r;
        start = 1'b1;
        step();
        start = 1'b0;
        tb_drive = 1'b0;
        rw = 1'b1;
        wait_idle();
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready0); end
        checks++; if (bus_data0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus_data0); end
        checks++; if (led0 !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led0); end
        checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", cnt3); end
        checks++; if ({act3, wp3, ovr3} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {act3, wp3, ovr3}); end
    endtask

    task automatic test_mode0_nowait();
        mode = 2'd0;
        addr = 41'h200;
        rw = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL t1_ready_low: got %b expected 0", ready0); end
        step();
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL t1_ready_back: got %b expected 1", ready0); end
        checks++; if (bus_data0 !== 8'hAA) begin errors++; $display("FAIL t1_data: got %h expected aa", bus_data0); end
        checks++; if (led0 !== 8'h01) begin errors++; $display("FAIL t1_led: got %h expected 01", led0); end
        checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL t1_op_count: got %0d expected 1", cnt0); end
        wait_idle();
    endtask

    task automatic test_mode1_wait();
        int cycles;
        mode = 2'd1;
        addr = 41'h1234;
        rw = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 0;
        while (ready3 == 1'b0 && cycles < 20) begin
            cycles++;
            step();
        end
        checks++; if (cycles != 4) begin errors++; $display("FAIL t2_busy_cycles: got %0d expected 4", cycles); end
        checks++; if (bus_data3 !== 8'h26) begin errors++; $display("FAIL t2_data: got %h expected 26", bus_data3); end
        checks++; if (cnt3 !== 16'd2) begin errors++; $display("FAIL t2_op_count: got %0d expected 2", cnt3); end
        wait_idle();
    endtask

    task automatic test_ram();
        mode = 2'd2;
        do_op(41'h010, 1'b0, 8'h5C);
        do_op(41'h210, 1'b0, 8'h77);
        do_op(41'h010, 1'b1, 8'h00);
        checks++; if (bus_data3 !== 8'h77) begin errors++; $display("FAIL t3_ram_wrap3: got %h expected 77", bus_data3); end
        checks++; if (bus_data0 !== 8'h77) begin errors++; $display("FAIL t3_ram_wrap0: got %h expected 77", bus_data0); end
        do_op(41'h011, 1'b0, 8'h3C);
        do_op(41'h011, 1'b1, 8'h00);
        checks++; if (bus_data3 !== 8'h3C) begin errors++; $display("FAIL t3_ram_neighbour: got %h expected 3c", bus_data3); end
    endtask

    task automatic test_write_protect();
        mode = 2'd3;
        do_op(41'h010, 1'b0, 8'h00);
        checks++; if (wp3 !== 1'b1) begin errors++; $display("FAIL t4_wp_err: got %b expected 1", wp3); end
        do_op(41'h010, 1'b1, 8'h00);
        checks++; if (bus_data3 !== 8'h77) begin errors++; $display("FAIL t4_ram_kept: got %h expected 77", bus_data3); end
        checks++; if (cnt3 !== 16'd9) begin errors++; $display("FAIL t4_count_before_clear: got %0d expected 9", cnt3); end
        checks++; if (ovr3 !== 1'b0) begin errors++; $display("FAIL t4_no_overrun: got %b expected 0", ovr3); end
        pulse_clear();
        checks++; if (wp3 !== 1'b0) begin errors++; $display("FAIL t4_wp_cleared: got %b expected 0", wp3); end
        checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL t4_count_cleared: got %0d expected 0", cnt3); end
    endtask

    task automatic test_overrun();
        pulse_clear();
        mode = 2'd1;
        rw = 1'b1;
        addr = 41'h1234;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        addr = 41'h00FF;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        checks++; if (ovr3 !== 1'b1) begin errors++; $display("FAIL t5_overrun: got %b expected 1", ovr3); end
        checks++; if (cnt3 !== 16'd1) begin errors++; $display("FAIL t5_op_count: got %0d expected 1", cnt3); end
        checks++; if (bus_data3 !== 8'h26) begin errors++; $display("FAIL t5_inflight_data: got %h expected 26", bus_data3); end
        checks++; if (bus_data0 !== 8'hFF) begin errors++; $display("FAIL t5_idle_target_data: got %h expected ff", bus_data0); end
        checks++; if (cnt0 !== 16'd2) begin errors++; $display("FAIL t5_idle_target_count: got %0d expected 2", cnt0); end
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL t5_idle_target_overrun: got %b expected 0", ovr0); end
    endtask

    task automatic test_same_edge_start();
        pulse_clear();
        mode = 2'd1;
        rw = 1'b1;
        addr = 41'h0100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL same_edge_ready: got %b expected 1", ready3); end
        checks++; if (ovr3 !== 1'b1) begin errors++; $display("FAIL same_edge_overrun: got %b expected 1", ovr3); end
        checks++; if (bus_data3 !== 8'h01) begin errors++; $display("FAIL same_edge_data: got %h expected 01", bus_data3); end
        step();
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL same_edge_not_accepted: got %b expected 1", ready3); end
        checks++; if (cnt3 !== 16'd1) begin errors++; $display("FAIL same_edge_count: got %0d expected 1", cnt3); end
        wait_idle();
    endtask

    task automatic test_activity();
        mode = 2'd0;
        rw = 1'b1;
        addr = 41'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (act3 !== 1'b1) begin errors++; $display("FAIL act_start: got %b expected 1", act3); end
        for (int i = 0; i < 14; i++) step();
        checks++; if (act3 !== 1'b1) begin errors++; $display("FAIL act_last_cycle: got %b expected 1", act3); end
        step();
        checks++; if (act3 !== 1'b0) begin errors++; $display("FAIL act_expired: got %b expected 0", act3); end
    endtask

    task automatic test_reset_midop_and_enable();
        mode = 2'd2;
        addr = 41'h010;
        rw = 1'b0;
        tb_wdata = 8'hEE;
        tb_drive = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        tb_drive = 1'b0;
        rw = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL t6_ready_after_reset: got %b expected 1", ready3); end
        checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL t6_count_after_reset: got %0d expected 0", cnt3); end
        do_op(41'h010, 1'b1, 8'h00);
        checks++; if (bus_data3 !== 8'h77) begin errors++; $display("FAIL t6_ram_unchanged: got %h expected 77", bus_data3); end
        enable = 1'b0;
        step();
        checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL t6_disabled_ready: got %b expected 0", ready3); end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL t6_disabled_still_low: got %b expected 0", ready3); end
        checks++; if (cnt3 !== 16'd1) begin errors++; $display("FAIL t6_disabled_count: got %0d expected 1", cnt3); end
        enable = 1'b1;
        step();
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL t6_reenabled_ready: got %b expected 1", ready3); end
    endtask

    initial begin
        test_reset();
        test_mode0_nowait();
        test_mode1_wait();
        test_ram();
        test_write_protect();
        test_overrun();
        test_same_edge_start();
        test_activity();
        test_reset_midop_and_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
